// File: rtl/db15_serial_reader.sv
// DB15 arcade adapter reader: clocks a 24-bit active-low 165-style shift chain
// and publishes two 12-button joystick words atomically once per frame.
module db15_serial_reader #(
    parameter int unsigned CLK_DIV = 24,
    parameter int unsigned GAP     = 16
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        JOY_DATA,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        frame_done
);

    localparam int unsigned DIV_W  = 8;
    localparam int unsigned GAP_W  = 8;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned NBITS  = 24;
    localparam int unsigned NBTN   = 12;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        LO,
        HI
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_nxt;
    logic [IDX_W-1:0]   bit_idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic [NBITS-1:0]   shreg;
    logic               sync1;
    logic               sync2;
    logic               capture;
    logic               finish;
    logic               load_nxt;
    logic               jclk_nxt;

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    // Free-running half-bit divider and input synchronizer
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            div_cnt <= '0;
            sync1   <= 1'b1;
            sync2   <= 1'b1;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            sync1   <= JOY_DATA;
            sync2   <= sync1;
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            gap_cnt <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
            bit_idx <= idx_nxt;
        end
    end

    // gap_cnt doubles as the tick counter for the two-tick load strobe
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        idx_nxt   = bit_idx;
        capture   = 1'b0;
        finish    = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (gap_cnt == GAP_W'(GAP - 1)) begin
                        state_nxt = LOAD;
                        gap_nxt   = '0;
                    end else begin
                        gap_nxt = gap_cnt + GAP_W'(1);
                    end
                end
                LOAD: begin
                    if (gap_cnt == GAP_W'(1)) begin
                        state_nxt = LO;
                        gap_nxt   = '0;
                        idx_nxt   = '0;
                    end else begin
                        gap_nxt = gap_cnt + GAP_W'(1);
                    end
                end
                LO: begin
                    capture   = 1'b1;
                    state_nxt = HI;
                end
                HI: begin
                    if (bit_idx == IDX_W'(NBITS - 1)) begin
                        finish    = 1'b1;
                        idx_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt   = bit_idx + IDX_W'(1);
                        state_nxt = LO;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        load_nxt = (state_nxt != LOAD);
        jclk_nxt = (state_nxt != LO);
    end

    // Adapter strobes follow the next state so they toggle on the same edge as the FSM
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            JOY_LOAD   <= 1'b1;
            JOY_CLK    <= 1'b1;
            frame_done <= 1'b0;
            shreg      <= '1;
            joystick1  <= '0;
            joystick2  <= '0;
        end else begin
            JOY_LOAD   <= load_nxt;
            JOY_CLK    <= jclk_nxt;
            frame_done <= finish;
            if (capture) begin
                shreg[bit_idx] <= sync2;
            end
            if (finish) begin
                joystick1 <= {4'b0000, ~shreg[NBTN-1:0]};
                joystick2 <= {4'b0000, ~shreg[NBITS-1:NBTN]};
            end
        end
    end

endmodule

// File: tb/tb_db15_serial_reader.sv
// Bench for db15_serial_reader: behavioural 24-bit adapter, frame-level
// reference model, waveform monitor and a small-parameter second instance.
module tb_db15_serial_reader;

    localparam int unsigned CLK_DIV = 24;
    localparam int unsigned GAP     = 16;
    localparam int unsigned PERIOD  = (GAP + 2 + 48) * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        joy_data = 1'b1;
    logic        joy_clk;
    logic        joy_load;
    logic [15:0] j1;
    logic [15:0] j2;
    logic        fd;

    logic        s_clk;
    logic        s_load;
    logic [15:0] s_j1;
    logic [15:0] s_j2;
    logic        s_fd;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;

    db15_serial_reader #(.CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
        .clk       (clk),
        .RESET     (rst),
        .JOY_DATA  (joy_data),
        .JOY_CLK   (joy_clk),
        .JOY_LOAD  (joy_load),
        .joystick1 (j1),
        .joystick2 (j2),
        .frame_done(fd)
    );

    db15_serial_reader #(.CLK_DIV(4), .GAP(1)) dut_small (
        .clk       (clk),
        .RESET     (rst),
        .JOY_DATA  (1'b1),
        .JOY_CLK   (s_clk),
        .JOY_LOAD  (s_load),
        .joystick1 (s_j1),
        .joystick2 (s_j2),
        .frame_done(s_fd)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Adapter model: parallel load while JOY_LOAD low, advance on JOY_CLK rise
    logic [23:0] pat = 24'hFFFFFF;
    logic        noise_en = 1'b0;
    logic        prev_jclk = 1'b1;
    int          ptr = 0;
    int          lo_cnt = 0;
    int          hi_cnt = 0;

    always @(negedge clk) begin
        logic intended;
        if (!joy_load) begin
            ptr    = 0;
            lo_cnt = 0;
            hi_cnt = 0;
        end else if (joy_clk) begin
            if (!prev_jclk) ptr = ptr + 1;
            hi_cnt = hi_cnt + 1;
            lo_cnt = 0;
        end else begin
            lo_cnt = lo_cnt + 1;
            hi_cnt = 0;
        end
        prev_jclk = joy_clk;
        intended = (ptr < 24) ? pat[ptr] : 1'b1;
        if (!noise_en)
            joy_data = intended;
        else if (joy_clk && hi_cnt >= 1 && hi_cnt <= 3 && ptr > 0)
            joy_data = joy_data;
        else if (!joy_clk && lo_cnt >= int'(CLK_DIV) - 6)
            joy_data = intended;
        else
            joy_data = ~joy_data;
    end

    // Waveform / frame monitor sampled just after each active edge
    int cyc = 0, load_low = 0, clk_run = 0, clk_pulses = 0, clk_badw = 0;
    int both_low = 0, frames = 0, fd_run = 0, fd_wide = 0, glitch = 0;
    int last_period = 0, last_load_low = 0, last_pulses = 0, last_badw = 0;
    logic [15:0] prev_j1 = '0, prev_j2 = '0;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            cyc = 0; load_low = 0; clk_run = 0; clk_pulses = 0; clk_badw = 0;
        end else begin
            cyc++;
            if (!joy_load) load_low++;
            if (!joy_clk) clk_run++;
            else if (clk_run != 0) begin
                clk_pulses++;
                if (clk_run != int'(CLK_DIV)) clk_badw++;
                clk_run = 0;
            end
            if (!joy_load && !joy_clk) both_low++;
            if (!fd && (j1 !== prev_j1 || j2 !== prev_j2)) glitch++;
            if (fd) begin
                fd_run++;
                if (fd_run > 1) fd_wide++;
                last_period = cyc; last_load_low = load_low;
                last_pulses = clk_pulses; last_badw = clk_badw;
                cyc = 0; load_low = 0; clk_pulses = 0; clk_badw = 0;
                frames++;
            end else begin
                fd_run = 0;
            end
        end
        prev_j1 = j1;
        prev_j2 = j2;
    end

    int s_cyc = 0, s_period = 0, s_frames = 0, s_run = 0, s_wide = 0;
    always @(posedge clk) begin
        #1;
        if (rst) s_cyc = 0;
        else begin
            s_cyc++;
            if (s_fd) begin
                s_run++;
                if (s_run > 1) s_wide++;
                s_period = s_cyc;
                s_cyc = 0;
                s_frames++;
            end else s_run = 0;
        end
    end

    task automatic wait_frame();
        int fr0 = frames;
        for (int n = 0; n < 3 * int'(PERIOD); n++) begin
            @(posedge clk);
            #2;
            if (frames != fr0) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL frame_timeout: got no frame_done expected one within %0d cycles", 3 * PERIOD);
    endtask

    task automatic wait_load_low(output int n);
        n = 0;
        for (int k = 0; k < 2 * int'(PERIOD); k++) begin
            @(posedge clk);
            #1;
            n++;
            if (!joy_load) return;
        end
    endtask

    function automatic logic [15:0] exp_p1(input logic [23:0] p);
        return {4'b0000, ~p[11:0]};
    endfunction
    function automatic logic [15:0] exp_p2(input logic [23:0] p);
        return {4'b0000, ~p[23:12]};
    endfunction

    initial begin
        int n;
        int fr_saved;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("rst_load", 32'(joy_load), 32'd1);
        check_eq("rst_jclk", 32'(joy_clk), 32'd1);
        check_eq("rst_j1", 32'(j1), 32'd0);
        check_eq("rst_j2", 32'(j2), 32'd0);
        check_eq("rst_fd", 32'(fd), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        wait_load_low(n);
        check_eq("first_load", 32'(n), 32'(GAP * CLK_DIV));

        wait_frame();
        check_eq("idle_period", 32'(last_period), 32'(PERIOD));
        check_eq("idle_j1", 32'(j1), 32'd0);
        check_eq("idle_j2", 32'(j2), 32'd0);
        check_eq("load_width", 32'(last_load_low), 32'd48);
        check_eq("clk_pulses", 32'(last_pulses), 32'd24);
        check_eq("clk_width", 32'(last_badw), 32'd0);

        pat = 24'hA5F00F;
        wait_frame();
        check_eq("fixed_j1", 32'(j1), 32'h0FF0);
        check_eq("fixed_j2", 32'(j2), 32'h05A0);
        check_eq("fixed_period", 32'(last_period), 32'(PERIOD));

        noise_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [23:0] p;
            p = 24'($urandom);
            if (i == 0) p = 24'h000000;
            pat = p;
            wait_frame();
            check_eq($sformatf("rand_j1_%0d", i), 32'(j1), 32'(exp_p1(p)));
            check_eq($sformatf("rand_j2_%0d", i), 32'(j2), 32'(exp_p2(p)));
        end

        // Abort a frame at bit 10 with a three-cycle reset
        pat = 24'($urandom);
        for (int k = 0; k < 3 * int'(PERIOD); k++) begin
            @(posedge clk);
            #2;
            if (clk_pulses == 10 && !joy_clk) break;
        end
        check_eq("pre_abort_bit", 32'(clk_pulses), 32'd10);
        fr_saved = frames;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_j1", 32'(j1), 32'd0);
        check_eq("abort_j2", 32'(j2), 32'd0);
        check_eq("abort_load", 32'(joy_load), 32'd1);
        check_eq("abort_jclk", 32'(joy_clk), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        wait_load_low(n);
        check_eq("restart_load", 32'(n), 32'(GAP * CLK_DIV));
        check_eq("abort_no_done", 32'(frames), 32'(fr_saved));
        wait_frame();
        check_eq("restart_period", 32'(last_period), 32'(PERIOD));
        check_eq("restart_j1", 32'(j1), 32'(exp_p1(pat)));
        check_eq("restart_j2", 32'(j2), 32'(exp_p2(pat)));

        check_eq("both_low", 32'(both_low), 32'd0);
        check_eq("fd_width", 32'(fd_wide), 32'd0);
        check_eq("partial_visible", 32'(glitch), 32'd0);
        check_eq("small_frames_seen", 32'(s_frames > 2), 32'd1);
        check_eq("small_period", 32'(s_period), 32'd204);
        check_eq("small_fd_width", 32'(s_wide), 32'd0);
        check_eq("small_j1", 32'(s_j1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
